// File: rtl/sccb_write_master.sv
// sccb_write_master: three-byte SCCB/I2C register write master.
// SCL push-pull, SDA open-drain via sda_oe, quarter-period sequencing.
module sccb_write_master #(
  parameter int         CLK_DIV  = 68,
  parameter logic [6:0] DEV_ADDR = 7'h21
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_data,
  input  logic       sda_i,
  output logic       scl,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_error
);

  localparam int QW = $clog2(CLK_DIV);
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_ACK,
    S_STOP, S_BUF, S_DONE
  } state_t;

  state_t          state, nstate;
  logic [QW-1:0]   qcnt;
  logic [1:0]      q, nq;
  logic [2:0]      bitcnt, nbit;
  logic [1:0]      byte_idx, nbyte;
  logic [7:0]      ra, rd, nra, nrd;
  logic [7:0]      cur;
  logic            nerr;
  logic            sda_s1, sda_s2;
  logic            tick, hi;
  logic            scl_n, oe_n, busy_n;

  assign tick = (qcnt == QMAX);

  always_comb begin
    nstate = state;
    nq     = q;
    nbit   = bitcnt;
    nbyte  = byte_idx;
    nra    = ra;
    nrd    = rd;
    nerr   = ack_error;
    unique case (state)
      S_IDLE: if (start) begin
        nstate = S_START;
        nq     = 2'd0;
        nra    = reg_addr;
        nrd    = reg_data;
        nerr   = 1'b0;
      end
      S_DONE: nstate = S_IDLE;
      default: if (tick) begin
        nq = q + 2'd1;
        if (q == 2'd3) begin
          unique case (state)
            S_START: begin
              nstate = S_BIT;
              nbit   = 3'd7;
              nbyte  = 2'd0;
            end
            S_BIT:
              if (bitcnt == 3'd0) nstate = S_ACK;
              else nbit = bitcnt - 3'd1;
            S_ACK:
              if (sda_s2) begin
                nerr   = 1'b1;
                nstate = S_STOP;
              end else if (byte_idx == 2'd2) begin
                nstate = S_STOP;
              end else begin
                nstate = S_BIT;
                nbit   = 3'd7;
                nbyte  = byte_idx + 2'd1;
              end
            S_STOP:  nstate = S_BUF;
            S_BUF:   nstate = S_DONE;
            default: nstate = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // Pins are decoded from the next state so they change with it.
  always_comb begin
    cur    = (nbyte == 2'd0) ? {DEV_ADDR, 1'b0} :
             (nbyte == 2'd1) ? ra : rd;
    hi     = nq[1];
    scl_n  = 1'b1;
    oe_n   = 1'b0;
    busy_n = !(nstate == S_IDLE || nstate == S_DONE);
    unique case (1'b1)
      nstate == S_START: oe_n = hi;
      nstate == S_BIT: begin
        scl_n = hi;
        oe_n  = !cur[nbit];
      end
      nstate == S_ACK: scl_n = hi;
      nstate == S_STOP: begin
        scl_n = hi;
        oe_n  = (nq != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      qcnt      <= '0;
      q         <= 2'd0;
      bitcnt    <= 3'd0;
      byte_idx  <= 2'd0;
      ra        <= 8'd0;
      rd        <= 8'd0;
      ack_error <= 1'b0;
      sda_s1    <= 1'b1;
      sda_s2    <= 1'b1;
      scl       <= 1'b1;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= nstate;
      q         <= nq;
      bitcnt    <= nbit;
      byte_idx  <= nbyte;
      ra        <= nra;
      rd        <= nrd;
      ack_error <= nerr;
      sda_s1    <= sda_i;
      sda_s2    <= sda_s1;
      if (state == S_IDLE || state == S_DONE || tick)
        qcnt <= '0;
      else
        qcnt <= qcnt + 1'b1;
      scl       <= scl_n;
      sda_oe    <= oe_n;
      busy      <= busy_n;
      done      <= (state == S_DONE);
    end
  end

endmodule

// File: tb/tb_sccb_write_master.sv
// tb_sccb_write_master: directed bench with a clock-sampled SCCB slave.
// Slave answers address slave_addr, registers 0..15.
module tb_sccb_write_master;

  localparam int CD = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] reg_addr = 8'd0;
  logic [7:0] reg_data = 8'd0;
  logic       sda_i;
  logic       scl, sda_oe, busy, done, ack_error;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int done_cnt = 0;
  int starts = 0;
  int stops = 0;

  logic [6:0] slave_addr = 7'h21;
  logic [7:0] mem [16];
  logic       s_oe = 1'b0;
  logic       s_active = 1'b0;
  logic       s_acking = 1'b0;
  logic       s_nack = 1'b0;
  logic       s_ack;
  int         s_bcnt = 0;
  int         s_byte = 0;
  logic [7:0] s_sh = 8'd0;
  logic [7:0] s_ptr = 8'd0;
  logic       pscl = 1'b1;
  logic       psda = 1'b1;
  logic       sda_bus;

  assign sda_bus = !(sda_oe || s_oe);
  assign sda_i   = sda_bus;

  sccb_write_master #(.CLK_DIV(CD), .DEV_ADDR(7'h21)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .reg_addr(reg_addr), .reg_data(reg_data), .sda_i(sda_i),
    .scl(scl), .sda_oe(sda_oe), .busy(busy), .done(done),
    .ack_error(ack_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (done) done_cnt++;
  end

  always @(negedge clk) begin
    logic cs;
    cs = sda_bus;
    if (scl && pscl && psda && !cs) begin
      starts++;
      s_active = 1'b1;
      s_bcnt = 0;
      s_byte = 0;
      s_acking = 1'b0;
      s_oe = 1'b0;
    end else if (scl && pscl && !psda && cs) begin
      stops++;
      s_active = 1'b0;
      s_acking = 1'b0;
      s_oe = 1'b0;
    end else if (s_active) begin
      if (!pscl && scl && !s_acking) begin
        s_sh = {s_sh[6:0], cs};
        s_bcnt++;
      end else if (pscl && !scl) begin
        if (s_acking) begin
          s_oe = 1'b0;
          s_acking = 1'b0;
          s_bcnt = 0;
          s_byte++;
          if (s_nack || s_byte == 3) s_active = 1'b0;
        end else if (s_bcnt == 8) begin
          s_ack = 1'b0;
          case (s_byte)
            0: s_ack = (s_sh == {slave_addr, 1'b0});
            1: begin
              s_ack = (s_sh < 8'd16);
              s_ptr = s_sh;
            end
            2: begin
              mem[s_ptr[3:0]] = s_sh;
              s_ack = 1'b1;
            end
            default: s_ack = 1'b0;
          endcase
          s_oe = s_ack;
          s_nack = !s_ack;
          s_acking = 1'b1;
        end
      end
    end
    pscl = scl;
    psda = cs;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  int t0;

  task automatic req(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_addr = a;
    reg_data = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    lat = done ? (cyc - t0) : -1;
  endtask

  initial begin
    int lat, st0, sp0, dc0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_scl", 32'(scl), 32'd1);
    chk("rst_oe", 32'(sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(ack_error), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // nominal write
    st0 = starts;
    sp0 = stops;
    req(8'h03, 8'hA5);
    chk("nom_busy", 32'(busy), 32'd1);
    wait_done(lat);
    chk("nom_lat", 32'(lat), 32'(120 * CD + 1));
    chk("nom_err", 32'(ack_error), 32'd0);
    chk("nom_mem", 32'(mem[3]), 32'hA5);
    chk("nom_start", 32'(starts - st0), 32'd1);
    chk("nom_stop", 32'(stops - sp0), 32'd1);
    repeat (5) @(negedge clk);

    // address NACK
    slave_addr = 7'h10;
    sp0 = stops;
    req(8'h05, 8'h77);
    wait_done(lat);
    chk("anack_lat", 32'(lat), 32'(48 * CD + 1));
    chk("anack_err", 32'(ack_error), 32'd1);
    chk("anack_mem", 32'(mem[5]), 32'h00);
    chk("anack_stop", 32'(stops - sp0), 32'd1);
    slave_addr = 7'h21;
    repeat (5) @(negedge clk);

    // register NACK
    req(8'h20, 8'h12);
    wait_done(lat);
    chk("rnack_lat", 32'(lat), 32'(84 * CD + 1));
    chk("rnack_err", 32'(ack_error), 32'd1);
    repeat (5) @(negedge clk);

    // start ignored while busy
    dc0 = done_cnt;
    req(8'h07, 8'h3C);
    chk("err_clr", 32'(ack_error), 32'd0);
    repeat (100) @(negedge clk);
    reg_addr = 8'h08;
    reg_data = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("busy_lat", 32'(lat), 32'(120 * CD + 1));
    repeat (600) @(negedge clk);
    chk("busy_done1", 32'(done_cnt - dc0), 32'd1);
    chk("busy_mem7", 32'(mem[7]), 32'h3C);
    chk("busy_mem8", 32'(mem[8]), 32'h00);

    // reset during byte 2
    req(8'h09, 8'h99);
    repeat (200) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mrst_scl", 32'(scl), 32'd1);
    chk("mrst_oe", 32'(sda_oe), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    req(8'h0A, 8'h5A);
    wait_done(lat);
    chk("post_lat", 32'(lat), 32'(120 * CD + 1));
    chk("post_err", 32'(ack_error), 32'd0);
    chk("post_mem", 32'(mem[10]), 32'h5A);
    chk("post_mem9", 32'(mem[9]), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
